// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART stream driver.
package spart_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_INIT_LO,
    ST_INIT_HI,
    ST_IDLE,
    ST_RX_READ,
    ST_TX_WRITE
  } state_t;

  // ioaddr encodings on the SPART bus
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam logic [7:0] CHAR_CR = 8'h0D;

  // Default baud divisors, indexed by br_cfg
  localparam logic [15:0] DEF_DIV_0 = 16'd651;
  localparam logic [15:0] DEF_DIV_1 = 16'd326;
  localparam logic [15:0] DEF_DIV_2 = 16'd163;
  localparam logic [15:0] DEF_DIV_3 = 16'd81;

  // Bus request as decoded from the current state
  typedef struct packed {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
  } bus_req_t;

  function automatic logic [15:0] sel_div(input logic [1:0]  cfg,
                                          input logic [15:0] d0,
                                          input logic [15:0] d1,
                                          input logic [15:0] d2,
                                          input logic [15:0] d3);
    case (cfg)
      2'b00:   return d0;
      2'b01:   return d1;
      2'b10:   return d2;
      default: return d3;
    endcase
  endfunction

endpackage

// File: rtl/spart_fifo.sv
// Byte FIFO with combinational head, synchronous clear and occupancy count.
module spart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clr,
  input  logic [7:0]                din,
  output logic [7:0]                dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  // Pointer and count bookkeeping; clear wins over any access in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  // Storage needs no reset; only slots behind the pointers are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spart_stream_driver.sv
// SPART driver: programs the baud divisor, buffers received bytes and
// writes them back either immediately (echo) or a line at a time (line).
module spart_stream_driver
  import spart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_0      = DEF_DIV_0,
  parameter logic [15:0] DIV_1      = DEF_DIV_1,
  parameter logic [15:0] DIV_2      = DEF_DIV_2,
  parameter logic [15:0] DIV_3      = DEF_DIV_3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          mode,
  input  logic                          rda,
  input  logic                          tbr,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          flushing
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t      state;
  logic [1:0]  br_cfg_q;
  logic        mode_q;
  logic        cfg_chg;
  logic [15:0] divisor;
  bus_req_t    req;
  logic [7:0]  drv_data;
  logic        drv_en;
  logic [7:0]  fifo_dout;
  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic        tx_eligible;

  // Any change of baud or mode restarts init and discards buffered data
  assign cfg_chg     = (br_cfg != br_cfg_q) || (mode != mode_q);
  assign divisor     = sel_div(br_cfg_q, DIV_0, DIV_1, DIV_2, DIV_3);
  assign fifo_push   = (state == ST_RX_READ) && !cfg_chg;
  assign fifo_pop    = (state == ST_TX_WRITE) && !cfg_chg;
  assign tx_eligible = !fifo_empty && (!mode_q || flushing);

  spart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (cfg_chg),
    .din   (databus),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Bus signals decoded from state alone, so reset releases the bus at once
  always_comb begin
    req      = '{cs: 1'b0, rw: 1'b0, addr: ADDR_DATA};
    drv_data = 8'h00;
    case (state)
      ST_INIT_LO: begin
        req      = '{cs: 1'b1, rw: 1'b0, addr: ADDR_DBL};
        drv_data = divisor[7:0];
      end
      ST_INIT_HI: begin
        req      = '{cs: 1'b1, rw: 1'b0, addr: ADDR_DBH};
        drv_data = divisor[15:8];
      end
      ST_RX_READ:  req = '{cs: 1'b1, rw: 1'b1, addr: ADDR_DATA};
      ST_TX_WRITE: begin
        req      = '{cs: 1'b1, rw: 1'b0, addr: ADDR_DATA};
        drv_data = fifo_dout;
      end
      default: ;
    endcase
  end

  assign iocs    = req.cs;
  assign iorw    = req.rw;
  assign ioaddr  = req.addr;
  assign drv_en  = req.cs && !req.rw;
  assign databus = drv_en ? drv_data : 8'hzz;

  // Main FSM; every access returns to IDLE so rda/tbr can settle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      br_cfg_q <= 2'b00;
      mode_q   <= 1'b0;
    end else begin
      br_cfg_q <= br_cfg;
      mode_q   <= mode;
      if (cfg_chg) begin
        state <= ST_INIT_LO;
      end else begin
        case (state)
          ST_BOOT:    state <= ST_INIT_LO;
          ST_INIT_LO: state <= ST_INIT_HI;
          ST_INIT_HI: state <= ST_IDLE;
          ST_IDLE: begin
            if (rda && !fifo_full)       state <= ST_RX_READ;
            else if (tbr && tx_eligible) state <= ST_TX_WRITE;
          end
          ST_RX_READ:  state <= ST_IDLE;
          ST_TX_WRITE: state <= ST_IDLE;
          default:     state <= ST_BOOT;
        endcase
      end
    end
  end

  // Line-mode burst flag: armed by CR or a filling push, disarmed when drained
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flushing <= 1'b0;
    end else if (cfg_chg || !mode_q) begin
      flushing <= 1'b0;
    end else if (fifo_push && (databus == CHAR_CR || fifo_cnt == CW'(FIFO_DEPTH - 1))) begin
      flushing <= 1'b1;
    end else if (fifo_pop && fifo_cnt == CW'(1)) begin
      flushing <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_stream_driver.sv
// Bench: SPART-side model feeds bytes on rda/databus, a monitor predicts each
// cycle's bus activity from a queue-based model and checks the DUT.
module tb_spart_stream_driver;

  localparam int DEPTH = 4;

  typedef enum {P_NONE, P_RD, P_WR} pred_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic       mode = 1'b0;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic [2:0] fifo_cnt;
  logic       flushing;
  logic [7:0] rx_drv = 8'h00;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  logic [7:0]  offer[$];
  logic [7:0]  exp_q[$];
  logic [15:0] div_tab [4] = '{16'd651, 16'd326, 16'd163, 16'd81};
  logic        flush_m = 1'b0;
  logic        pend = 1'b0;
  logic [1:0]  m_br = 2'b01;
  logic        m_mode = 1'b0;
  int          init_step = 3;
  pred_t       pred = P_NONE;

  // SPART side drives data during reads; pullups make a released bus read FF
  assign databus = (iocs && iorw) ? rx_drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (databus[g]);
  end

  always #5 clk = ~clk;

  spart_stream_driver #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .mode     (mode),
    .rda      (rda),
    .tbr      (tbr),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .fifo_cnt (fifo_cnt),
    .flushing (flushing)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor / reference model, evaluated mid-cycle
  initial begin : mon
    logic chg, rd, wr;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (pend && offer.size() > 0) void'(offer.pop_front());
      pend   = 1'b0;
      rda    = (offer.size() > 0);
      rx_drv = rda ? offer[0] : 8'h00;
      if (rst) begin
        exp_q.delete();
        flush_m   = 1'b0;
        init_step = 3;
        pred      = P_NONE;
        m_br      = br_cfg;
        m_mode    = mode;
        check("rst_iocs", 32'(iocs), 32'd0);
        check("rst_bus", 32'(databus), 32'hFF);
        check("rst_cnt", 32'(fifo_cnt), 32'd0);
        check("rst_flush", 32'(flushing), 32'd0);
      end else begin
        check("fifo_cnt", 32'(fifo_cnt), 32'(exp_q.size()));
        check("flushing", 32'(flushing), 32'(flush_m));
        chg = (br_cfg != m_br) || (mode != m_mode);
        rd  = iocs && iorw;
        wr  = iocs && !iorw && (ioaddr == 2'b00);
        case (init_step)
          3: check("boot_iocs", 32'(iocs), 32'd0);
          2: begin
            check("init_lo_bus", 32'({iocs, iorw, ioaddr}), 32'b1010);
            check("init_lo_data", 32'(databus), 32'(div_tab[m_br][7:0]));
          end
          1: begin
            check("init_hi_bus", 32'({iocs, iorw, ioaddr}), 32'b1011);
            check("init_hi_data", 32'(databus), 32'(div_tab[m_br][15:8]));
          end
          default: begin
            case (pred)
              P_RD:    check("exp_read", 32'({iocs, iorw, ioaddr}), 32'b1100);
              P_WR:    check("exp_write", 32'({iocs, iorw, ioaddr}), 32'b1000);
              default: begin
                check("exp_idle", 32'(iocs), 32'd0);
                check("idle_bus_float", 32'(databus), 32'hFF);
              end
            endcase
            if (rd) begin
              b    = (offer.size() > 0) ? offer[0] : 8'h00;
              pend = 1'b1;
              if (!chg) begin
                exp_q.push_back(b);
                if (m_mode && (b == 8'h0D || exp_q.size() == DEPTH)) flush_m = 1'b1;
              end
            end
            if (wr && exp_q.size() > 0) begin
              check("tx_data", 32'(databus), 32'(exp_q[0]));
              if (!chg) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) flush_m = 1'b0;
              end
            end
          end
        endcase
        // Predict next cycle
        if (chg) begin
          exp_q.delete();
          flush_m   = 1'b0;
          init_step = 2;
          m_br      = br_cfg;
          m_mode    = mode;
          pred      = P_NONE;
        end else if (init_step != 0) begin
          init_step--;
          pred = P_NONE;
        end else if (iocs) begin
          pred = P_NONE;
        end else if (rda && exp_q.size() < DEPTH) begin
          pred = P_RD;
        end else if (tbr && exp_q.size() > 0 && (!m_mode || flush_m)) begin
          pred = P_WR;
        end else begin
          pred = P_NONE;
        end
      end
    end
  end

  // Stimulus
  initial begin : stim
    logic got;
    int   r;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Echo: two bytes, tbr high
    tbr = 1'b1;
    offer.push_back(8'h41);
    offer.push_back(8'h42);
    tick(16);

    // Line mode: nothing goes out until CR
    mode = 1'b1;
    tick(5);
    offer.push_back(8'h68);
    offer.push_back(8'h69);
    offer.push_back(8'h0D);
    tick(24);

    // Echo with tbr low: FIFO fills, remaining bytes wait on rda
    mode = 1'b0;
    tbr  = 1'b0;
    tick(5);
    for (int i = 0; i < 6; i++) offer.push_back(8'(8'h30 + i));
    tick(20);
    check("full_cnt", 32'(fifo_cnt), 32'd4);
    check("held_bytes", 32'(offer.size()), 32'd2);
    tbr = 1'b1;
    tick(30);

    // Reconfigure with data buffered
    tbr    = 1'b0;
    br_cfg = 2'b00;
    tick(5);
    for (int i = 0; i < 3; i++) offer.push_back(8'(8'h50 + i));
    tick(12);
    check("buf3_cnt", 32'(fifo_cnt), 32'd3);
    br_cfg = 2'b11;
    tick(3);
    check("reconf_clr", 32'(fifo_cnt), 32'd0);
    tbr = 1'b1;
    tick(5);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4)      mode = ~mode;
      else if (r < 6) br_cfg = 2'($urandom_range(0, 3));
      tbr = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0 && offer.size() < 6)
        offer.push_back(($urandom_range(0, 5) == 0) ? 8'h0D : 8'($urandom_range(0, 255)));
      tick(int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a TX_WRITE
    mode = 1'b0;
    tbr  = 1'b1;
    tick(5);
    for (int i = 0; i < 4; i++) offer.push_back(8'(8'hC0 + i));
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      #1;
      got = iocs && !iorw && (ioaddr == 2'b00);
    end
    check("tx_seen", 32'(got), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_iocs", 32'(iocs), 32'd0);
    check("rst_async_bus", 32'(databus), 32'hFF);
    tick(3);
    rst = 1'b0;
    tick(6);

    // Drain everything in echo mode
    for (int i = 0; i < 400 && !(offer.size() == 0 && fifo_cnt == 0 && !pend); i++) tick(1);
    check("drain_offer", 32'(offer.size()), 32'd0);
    check("drain_cnt", 32'(fifo_cnt), 32'd0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout want finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
